dffram_nr1w_ctrl: RTL and testbench
===================================

// Module: dffram_nr1w_ctrl
// PURPOSE
//  Parametrised DFF register file: one write port, NR read ports, non-power-of-two depth.
//  Adds per-lane write masking, a write-through bypass, and a per-port buffered/unbuffered read option.
//  Includes a hardware clear sequencer and sticky error flags.
//  Sits behind the TT pin wrapper; it replaces the fixed 2R1W nibble RAM as the storage core.
// PARAMETERS
//  DW     8   data word width, bits
//  LW     4   write-lane width, bits; DW % LW == 0; NL = DW/LW lanes
//  DEPTH  22  number of words, 2..2**AW; need not be a power of two
//  AW     5   address width; must satisfy 2**AW >= DEPTH
//  NR     2   number of read ports, >= 1
// PORTS
//  clk       in   1       rising-edge clock
//  rst_n     in   1       asynchronous active-low reset
//  cfg_rbuf  in   NR      per read port: 1 = buffered (registered) read, 0 = unbuffered
//  cfg_wthru in   1       1 = write-through bypass onto unbuffered read paths
//  init_req  in   1       1-cycle pulse; starts a clear sweep when the block is idle
//  w_en      in   1       write request
//  w_addr    in   AW      write address
//  w_data    in   DW      write data
//  w_mask    in   NL      lane enables; bit k covers w_data[k*LW +: LW]
//  r_addr    in   NR*AW   read address for port i at [i*AW +: AW]
//  r_data    out  NR*DW   read data for port i at [i*DW +: DW]
//  busy      out  1       clear sweep in progress
//  err       out  2       sticky: [0] out-of-range write, [1] write dropped while busy
//  clr_err   in   1       synchronous clear of err; a new error in the same cycle wins
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//   - FSM enters CLEAR with ptr=0; busy=1; err=0; read buffer registers=0.
//   - Storage array has no reset; it is zeroed by the sweep.
//  FSM states IDLE and CLEAR:
//   - CLEAR writes 0 to mem[ptr] on each clk and increments ptr.
//   - The edge at ptr==DEPTH-1 writes the last word and moves to IDLE, so busy=0 from then on.
//   - After rst_n rises, busy is high for exactly DEPTH rising edges.
//   - IDLE with init_req=1: next state is CLEAR, ptr=0. init_req while in CLEAR is ignored.
//   - rst_n asserted mid-sweep restarts the sweep from ptr=0.
//  Write acceptance: acc = w_en & !busy & (w_addr < DEPTH).
//   - On acc, lane k of mem[w_addr] <= w_data lane k where w_mask[k]=1; other lanes hold.
//   - w_en & busy: write is dropped; err[1] is set.
//   - w_en & !busy & (w_addr >= DEPTH): write is dropped; err[0] is set. err[0] is not set while busy.
//  Read port i, combinational value cv_i:
//   - r_addr_i >= DEPTH or busy=1: cv_i = 0.
//   - cfg_wthru & acc & (r_addr_i == w_addr): cv_i = merged word, i.e. mask-selected lanes
//     from w_data and the remaining lanes from the current mem word.
//   - Otherwise cv_i = mem[r_addr_i].
//  Output mux per port:
//   - The buffer register loads cv_i on every clk.
//   - r_data_i = cfg_rbuf[i] ? buffer : cv_i.
//   - Latency: 0 cycles unbuffered, 1 cycle buffered.
//   - With cfg_wthru=0, an unbuffered read of the address being written shows the old data
//     until the next edge.
//  Simultaneous events:
//   - Any number of ports may read the same address.
//   - Read and write of the same address follow the write-through rule above.
//   - w_mask = 0 with acc=1: no storage change and no error; it still counts as a hit for the bypass.
//  cfg_* inputs are treated as quasi-static. Changing them mid-operation takes effect on the
//  next combinational evaluation, with no glitch guarantee.
// TESTING (defaults DW=8, LW=4, DEPTH=22, NR=2)
//  1. Release rst_n -> busy=1 for exactly 22 edges, then 0; r_data=0 throughout;
//     every address reads 0x00 afterwards.
//  2. Write 0xA5 to addr 3, mask 2'b11, cfg_wthru=0, port0 unbuffered on addr 3 ->
//     0x00 in the write cycle, 0xA5 after; repeat with cfg_wthru=1 -> 0xA5 in the write cycle.
//  3. Over 0xA5 at addr 3, write 0x3C with mask 2'b01 -> addr 3 reads 0xAC on both ports.
//  4. Write to addr 25 -> no storage change, err=2'b01; read addr 25 -> 0x00;
//     assert clr_err -> err=2'b00.
//  5. cfg_rbuf=2'b10; step port1 through addr 0,1,2 holding 0x11,0x22,0x33 ->
//     port1 lags one cycle, port0 follows with no lag.
//  6. init_req in IDLE, then w_en during the sweep -> err[1]=1 and the write is lost;
//     pulse rst_n low mid-sweep -> busy runs 22 more edges and all words read 0.

Source files
------------

// File: rtl/dffram_nr1w_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dffram_nr1w_ctrl
// Brief   : DFF register file, 1 write / NR read ports, lane-masked writes,
//           write-through bypass, per-port buffered reads, clear sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module dffram_nr1w_ctrl #(
  parameter int DW    = 8,
  parameter int LW    = 4,
  parameter int DEPTH = 22,
  parameter int AW    = 5,
  parameter int NR    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NR-1:0]    cfg_rbuf_i,
  input  logic             cfg_wthru_i,
  input  logic             init_req_i,
  input  logic             w_en_i,
  input  logic [AW-1:0]    w_addr_i,
  input  logic [DW-1:0]    w_data_i,
  input  logic [DW/LW-1:0] w_mask_i,
  input  logic [NR*AW-1:0] r_addr_i,
  output logic [NR*DW-1:0] r_data_o,
  output logic             busy_o,
  output logic [1:0]       err_o,
  input  logic             clr_err_i
);

  localparam int            NL        = DW / LW;
  localparam logic [AW:0]   DEPTH_EXT = DEPTH[AW:0];
  localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [1:0]      err_q, err_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            busy;
  logic            wr_in_range;
  logic            wr_acc;
  logic [DW-1:0]   wr_merge;

  assign busy        = (state_q == ST_CLEAR);
  assign wr_in_range = ({1'b0, w_addr_i} < DEPTH_EXT);
  assign wr_acc      = w_en_i & ~busy & wr_in_range;
  assign busy_o      = busy;
  assign err_o       = err_q;

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d   = ptr_q + AW'(1);
        end
      end
      default: begin
        if (init_req_i) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
    endcase
  end

  // New errors override a simultaneous clear.
  always_comb begin
    err_d = clr_err_i ? 2'b00 : err_q;
    if (w_en_i & ~busy & ~wr_in_range) err_d[0] = 1'b1;
    if (w_en_i & busy)                 err_d[1] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Storage: no reset, zeroed by the sweep
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_merge = mem_q[w_addr_i];
    for (int k = 0; k < NL; k++) begin
      if (w_mask_i[k]) wr_merge[k*LW +: LW] = w_data_i[k*LW +: LW];
    end
  end

  always_ff @(posedge clk) begin
    if (busy) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_acc) begin
      mem_q[w_addr_i] <= wr_merge;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] raddr;
    logic          rd_ok;
    logic [DW-1:0] cv;
    logic [DW-1:0] rbuf_q;

    assign raddr = r_addr_i[i*AW +: AW];
    assign rd_ok = ({1'b0, raddr} < DEPTH_EXT) & ~busy;

    always_comb begin
      cv = '0;
      if (rd_ok) begin
        if (cfg_wthru_i & wr_acc & (raddr == w_addr_i)) cv = wr_merge;
        else                                            cv = mem_q[raddr];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rbuf_q <= '0;
      else        rbuf_q <= cv;
    end

    assign r_data_o[i*DW +: DW] = cfg_rbuf_i[i] ? rbuf_q : cv;
  end

endmodule
`default_nettype wire

// File: tb/tb_dffram_nr1w_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dffram_nr1w_ctrl
// Brief   : Scoreboard bench for dffram_nr1w_ctrl with directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dffram_nr1w_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cfg_rbuf;
  logic        cfg_wthru;
  logic        init_req;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [7:0]  w_data;
  logic [1:0]  w_mask;
  logic [9:0]  r_addr;
  logic [15:0] r_data;
  logic        busy;
  logic [1:0]  err;
  logic        clr_err;

  dffram_nr1w_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_rbuf_i (cfg_rbuf),
    .cfg_wthru_i(cfg_wthru),
    .init_req_i (init_req),
    .w_en_i     (w_en),
    .w_addr_i   (w_addr),
    .w_data_i   (w_data),
    .w_mask_i   (w_mask),
    .r_addr_i   (r_addr),
    .r_data_o   (r_data),
    .busy_o     (busy),
    .err_o      (err),
    .clr_err_i  (clr_err)
  );

  always #5 clk = ~clk;

  localparam int K_RD   = 0;
  localparam int K_BUSY = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int         cyc;
    int         kind;
    int         port;
    logic [7:0] val;
  } exp_t;

  exp_t sbq[$];
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due in the current cycle, sampled at negedge.
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] got;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      n_chk++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL stale kind=%0d port=%0d cyc=%0d (never sampled), required %02h",
                 e.kind, e.port, e.cyc, e.val);
      end else begin
        case (e.kind)
          K_RD:    got = r_data[e.port*8 +: 8];
          K_BUSY:  got = {7'd0, busy};
          default: got = {6'd0, err};
        endcase
        if (got !== e.val) begin
          n_bad++;
          $display("FAIL %s port=%0d cyc=%0d got=%02h required=%02h",
                   (e.kind == K_RD) ? "rdata" : (e.kind == K_BUSY) ? "busy" : "err",
                   e.port, cyc, got, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int port, input logic [7:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.port = port;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic exp_rd(input logic [7:0] v0, input logic [7:0] v1);
    push(K_RD, 0, v0);
    push(K_RD, 1, v1);
  endtask

  task automatic wr(input logic en, input logic [4:0] a, input logic [7:0] d,
                    input logic [1:0] m);
    w_en   = en;
    w_addr = a;
    w_data = d;
    w_mask = m;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    r_addr = {a1, a0};
  endtask

  task automatic sweep_check(input bit pulse_init);
    for (int k = 0; k < 22; k++) begin
      rd(5'(k), 5'(21 - k));
      init_req = (pulse_init && k == 10);
      push(K_BUSY, 0, 8'h01);
      exp_rd(8'h00, 8'h00);
      tick();
    end
    init_req = 1'b0;
    push(K_BUSY, 0, 8'h00);
    for (int a = 0; a < 22; a++) begin
      rd(5'(a), 5'(21 - a));
      exp_rd(8'h00, 8'h00);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_rbuf = 2'b00; cfg_wthru = 1'b0; init_req = 1'b0;
    clr_err = 1'b0; wr(1'b0, 5'd0, 8'h00, 2'b00); rd(5'd0, 5'd0);

    // Reset state
    tick();
    push(K_BUSY, 0, 8'h01); push(K_ERR, 0, 8'h00); exp_rd(8'h00, 8'h00);
    tick();
    rst_n = 1'b1;
    sweep_check(1'b0);

    // Write 0xA5 @3 without bypass: old data during write cycle
    rd(5'd3, 5'd3); wr(1'b1, 5'd3, 8'hA5, 2'b11);
    exp_rd(8'h00, 8'h00); tick();
    wr(1'b0, 5'd3, 8'h00, 2'b00);
    exp_rd(8'hA5, 8'hA5); tick();

    // Bypass enabled: new data visible in the write cycle
    cfg_wthru = 1'b1;
    wr(1'b1, 5'd3, 8'h5A, 2'b11);
    exp_rd(8'h5A, 8'h5A); tick();
    wr(1'b0, 5'd3, 8'h00, 2'b00);
    exp_rd(8'h5A, 8'h5A); tick();
    wr(1'b1, 5'd3, 8'hA5, 2'b11);
    exp_rd(8'hA5, 8'hA5); tick();

    // Lane mask 01 over 0xA5 with 0x3C -> 0xAC
    wr(1'b1, 5'd3, 8'h3C, 2'b01);
    exp_rd(8'hAC, 8'hAC); tick();
    wr(1'b0, 5'd3, 8'h00, 2'b00);
    exp_rd(8'hAC, 8'hAC); tick();
    // Mask 00: bypass shows current word, no change, no error
    wr(1'b1, 5'd3, 8'hFF, 2'b00);
    exp_rd(8'hAC, 8'hAC); push(K_ERR, 0, 8'h00); tick();
    wr(1'b0, 5'd3, 8'h00, 2'b00);
    exp_rd(8'hAC, 8'hAC); push(K_ERR, 0, 8'h00); tick();

    // Out-of-range write and reads, error clear
    cfg_wthru = 1'b0;
    rd(5'd25, 5'd3); wr(1'b1, 5'd25, 8'hFF, 2'b11);
    exp_rd(8'h00, 8'hAC); push(K_ERR, 0, 8'h00); tick();
    wr(1'b0, 5'd0, 8'h00, 2'b00); rd(5'd22, 5'd21);
    exp_rd(8'h00, 8'h00); push(K_ERR, 0, 8'h01); tick();
    rd(5'd3, 5'd25);
    exp_rd(8'hAC, 8'h00);
    clr_err = 1'b1; push(K_ERR, 0, 8'h01); tick();
    clr_err = 1'b0; push(K_ERR, 0, 8'h00); tick();
    clr_err = 1'b1; wr(1'b1, 5'd30, 8'h12, 2'b11); push(K_ERR, 0, 8'h00); tick();
    clr_err = 1'b0; wr(1'b0, 5'd0, 8'h00, 2'b00); push(K_ERR, 0, 8'h01); tick();
    clr_err = 1'b1; tick();
    clr_err = 1'b0; push(K_ERR, 0, 8'h00); tick();

    // Load 0x11/0x22/0x33 at addr 0..2
    for (int a = 0; a < 3; a++) begin
      rd(5'(a), 5'd3);
      wr(1'b1, 5'(a), 8'((a + 1) * 8'h11), 2'b11);
      exp_rd(8'h00, 8'hAC);
      tick();
    end
    wr(1'b0, 5'd0, 8'h00, 2'b00);

    // Port1 buffered lags one cycle, port0 unbuffered
    cfg_rbuf = 2'b10;
    rd(5'd3, 5'd3); tick();
    rd(5'd0, 5'd0); exp_rd(8'h11, 8'hAC); tick();
    rd(5'd1, 5'd1); exp_rd(8'h22, 8'h11); tick();
    rd(5'd2, 5'd2); exp_rd(8'h33, 8'h22); tick();
    exp_rd(8'h33, 8'h33); tick();
    cfg_rbuf = 2'b00;

    // init_req sweep, writes during busy dropped
    init_req = 1'b1; push(K_BUSY, 0, 8'h00); tick();
    init_req = 1'b0; wr(1'b1, 5'd5, 8'h77, 2'b11);
    push(K_BUSY, 0, 8'h01); push(K_ERR, 0, 8'h00); exp_rd(8'h00, 8'h00); tick();
    wr(1'b1, 5'd25, 8'h77, 2'b11); push(K_ERR, 0, 8'h02); tick();
    wr(1'b0, 5'd0, 8'h00, 2'b00); push(K_ERR, 0, 8'h02); tick();
    tick(); tick();

    // Asynchronous reset mid-sweep restarts the full sweep
    rst_n = 1'b0;
    #1 push(K_BUSY, 0, 8'h01); push(K_ERR, 0, 8'h00);
    tick();
    rst_n = 1'b1;
    sweep_check(1'b1);

    tick(); tick();
    if (sbq.size() != 0) begin
      n_chk++;
      n_bad++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
